// File: rtl/commit_trace_fifo.sv
// Commit-record trace FIFO: captures writeback records with a nonzero strobe and
// reports overflow by dropping. Optional capture-cycle stamps: COMMIT_TRACE_STAMP_EN.
module commit_trace_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              in_pc,
    input  logic [3:0]               in_wen,
    input  logic [4:0]               in_wnum,
    input  logic [31:0]              in_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [3:0]               out_wen,
    output logic [4:0]               out_wnum,
    output logic [31:0]              out_wdata,
    output logic [31:0]              out_stamp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [31:0]              dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = 32 + 4 + 5 + 32;

    logic [AW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;
    logic [31:0]   dropped_reg;

    // Records packed as {pc, wen, wnum, wdata}; read asynchronously at the head.
    logic [RW-1:0] rec_mem [DEPTH];
    logic [RW-1:0] head_rec;

    logic push, pop, accept, drop;

    assign push   = (in_wen != 4'b0);
    assign pop    = out_valid & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign accept = push & ((count_reg < CW'(DEPTH)) | pop);
    assign drop   = push & ~accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            dropped_reg  <= '0;
        end else begin
            if (accept) tail_reg <= tail_reg + AW'(1);
            if (pop)    head_reg <= head_reg + AW'(1);
            case ({accept, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                overflow_reg <= 1'b1;
                if (dropped_reg != 32'hFFFF_FFFF) dropped_reg <= dropped_reg + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) rec_mem[tail_reg] <= {in_pc, in_wen, in_wnum, in_wdata};
    end

    assign out_valid = (count_reg != '0);
    assign head_rec  = out_valid ? rec_mem[head_reg] : '0;
    assign out_pc    = head_rec[72:41];
    assign out_wen   = head_rec[40:37];
    assign out_wnum  = head_rec[36:32];
    assign out_wdata = head_rec[31:0];
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign dropped   = dropped_reg;

`ifdef COMMIT_TRACE_STAMP_EN
    logic [31:0] cycle_reg;
    logic [31:0] stamp_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) cycle_reg <= '0;
        else       cycle_reg <= cycle_reg + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) stamp_mem[tail_reg] <= cycle_reg;
    end

    assign out_stamp = out_valid ? stamp_mem[head_reg] : 32'h0;
`else
    assign out_stamp = 32'h0;
`endif

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Randomized self-checking bench for commit_trace_fifo against a queue-based model.
module tb_commit_trace_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_pc;
    logic [3:0]  in_wen;
    logic [4:0]  in_wnum;
    logic [31:0] in_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_wen;
    logic [4:0]  out_wnum;
    logic [31:0] out_wdata;
    logic [31:0] out_stamp;
    logic [4:0]  count;
    logic        overflow;
    logic [31:0] dropped;

    commit_trace_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_pc(in_pc), .in_wen(in_wen), .in_wnum(in_wnum), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_wen(out_wen), .out_wnum(out_wnum), .out_wdata(out_wdata),
        .out_stamp(out_stamp), .count(count), .overflow(overflow), .dropped(dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [31:0] stamp;
    } rec_t;

    rec_t        q[$];
    bit          m_ovf;
    logic [31:0] m_drop;
    logic [31:0] m_cyc;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] exp_stamp();
`ifdef COMMIT_TRACE_STAMP_EN
        return (q.size() > 0) ? q[0].stamp : 32'h0;
`else
        return 32'h0;
`endif
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle outputs.
    task automatic tick(input bit rst, input logic [31:0] pc, input logic [3:0] wen,
                        input logic [4:0] wnum, input logic [31:0] wdata, input bit rdy);
        bit   do_pop, do_acc;
        rec_t r;
        reset = rst; in_pc = pc; in_wen = wen; in_wnum = wnum; in_wdata = wdata; out_ready = rdy;
        @(posedge clk);
        if (rst) begin
            q.delete(); m_ovf = 0; m_drop = 0; m_cyc = 0;
        end else begin
            do_pop = (q.size() > 0) && rdy;
            do_acc = (wen != 0) && ((q.size() < DEPTH) || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_acc) begin
                r.pc = pc; r.wen = wen; r.wnum = wnum; r.wdata = wdata; r.stamp = m_cyc;
                q.push_back(r);
            end else if (wen != 0) begin
                m_ovf = 1;
                if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
            end
            m_cyc = m_cyc + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 32'hDEAD_BEEF, 4'hF, 5'd3, 32'h55, 1);
        tick(1, 0, 0, 0, 0, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (overflow !== 1'b0 || dropped !== 32'd0) begin n_err++; $display("FAIL reset_ovf got %0b/%0d want 0/0", overflow, dropped); end
        n_cmp++; if ({out_pc, out_wen, out_wnum, out_wdata, out_stamp} !== '0) begin n_err++; $display("FAIL reset_data got pc=%h wen=%h wnum=%0d wdata=%h stamp=%h want all 0", out_pc, out_wen, out_wnum, out_wdata, out_stamp); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 32'hBFC0_0000, 4'hF, 5'd5, 32'h1234, 0);
        tick(0, 0, 0, 0, 0, 0);
        n_cmp++; if (out_valid !== 1'b1 || count !== 5'd1) begin n_err++; $display("FAIL single_valid got v=%0b cnt=%0d want 1/1", out_valid, count); end
        n_cmp++; if (out_pc !== 32'hBFC0_0000 || out_wen !== 4'hF || out_wnum !== 5'd5 || out_wdata !== 32'h1234)
            begin n_err++; $display("FAIL single_data got %h/%h/%0d/%h want bfc00000/f/5/1234", out_pc, out_wen, out_wnum, out_wdata); end
`ifdef COMMIT_TRACE_STAMP_EN
        n_cmp++; if (out_stamp !== 32'd1) begin n_err++; $display("FAIL single_stamp got %0d want 1", out_stamp); end
`else
        n_cmp++; if (out_stamp !== 32'd0) begin n_err++; $display("FAIL single_stamp got %0d want 0", out_stamp); end
`endif
        $display("test_single done");
    endtask

    task automatic test_filter();
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, $urandom, 4'h0, 5'($urandom), $urandom, 0);
        tick(0, 32'h0000_0040, 4'h3, 5'd0, 32'hCAFE_0001, 0);
        tick(0, 0, 0, 0, 0, 0);
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL filter_count got %0d want 1", count); end
        n_cmp++; if (out_wen !== 4'h3 || out_pc !== 32'h40 || out_wnum !== 5'd0 || out_wdata !== 32'hCAFE_0001)
            begin n_err++; $display("FAIL filter_data got %h/%h/%0d/%h want 40/3/0/cafe0001", out_pc, out_wen, out_wnum, out_wdata); end
        $display("test_filter done");
    endtask

    task automatic test_fill_overflow();
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) tick(0, 32'(i * 4), 4'hF, 5'(i), $urandom, 0);
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fill_count got %0d want 16", count); end
        n_cmp++; if (overflow !== 1'b1 || dropped !== 32'd2) begin n_err++; $display("FAIL fill_ovf got %0b/%0d want 1/2", overflow, dropped); end
        n_cmp++; if (out_pc !== 32'd0) begin n_err++; $display("FAIL fill_head got %h want 0", out_pc); end
        $display("test_fill_overflow done");
    endtask

    task automatic test_full_pop();
        tick(0, 32'h100, 4'hF, 5'd7, 32'h77, 1);
        n_cmp++; if (count !== 5'd16 || dropped !== 32'd2) begin n_err++; $display("FAIL fullpop_count got %0d/%0d want 16/2", count, dropped); end
        n_cmp++; if (out_pc !== 32'd4) begin n_err++; $display("FAIL fullpop_head got %h want 4", out_pc); end
        for (int i = 0; i < 16; i++) begin
            logic [31:0] want;
            want = (i < 15) ? 32'((i + 1) * 4) : 32'h100;
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== want) begin n_err++; $display("FAIL drain_%0d got v=%0b pc=%h want 1/%h", i, out_valid, out_pc, want); end
            tick(0, 0, 0, 0, 0, 1);
        end
        n_cmp++; if (out_valid !== 1'b0 || out_pc !== 32'd0) begin n_err++; $display("FAIL drain_empty got v=%0b pc=%h want 0/0", out_valid, out_pc); end
        $display("test_full_pop done");
    endtask

    task automatic test_streaming();
        logic [31:0] next_pc = 32'h1000;
        int          seen = 0;
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            if (count > 5'd1) begin n_err++; $display("FAIL stream_count got %0d want <=1", count); end
            n_cmp++;
            if (out_valid) begin
                n_cmp++;
                if (out_pc !== next_pc) begin n_err++; $display("FAIL stream_order got %h want %h", out_pc, next_pc); end
                next_pc = next_pc + 4; seen++;
            end
            tick(0, 32'h1000 + 32'(i * 4), 4'hF, 5'd1, 32'(i), 1);
        end
        n_cmp++; if (overflow !== 1'b0 || seen != 99) begin n_err++; $display("FAIL stream_end got ovf=%0b seen=%0d want 0/99", overflow, seen); end
        $display("test_streaming done");
    endtask

    task automatic test_random();
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            int          rdy_pct;
            logic [3:0]  w;
            rdy_pct = ((i / 100) % 2 == 0) ? 20 : 80;
            w = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            n_cmp++;
            if (out_valid !== (q.size() > 0) || count !== 5'(q.size()) || overflow !== m_ovf || dropped !== m_drop) begin
                n_err++; $display("FAIL rand_state_%0d got v=%0b cnt=%0d ovf=%0b drop=%0d want %0b/%0d/%0b/%0d",
                    i, out_valid, count, overflow, dropped, q.size() > 0, q.size(), m_ovf, m_drop);
            end
            n_cmp++;
            if (q.size() > 0) begin
                if (out_pc !== q[0].pc || out_wen !== q[0].wen || out_wnum !== q[0].wnum || out_wdata !== q[0].wdata || out_stamp !== exp_stamp()) begin
                    n_err++; $display("FAIL rand_head_%0d got %h/%h/%0d/%h/%0d want %h/%h/%0d/%h/%0d", i, out_pc, out_wen, out_wnum, out_wdata, out_stamp,
                        q[0].pc, q[0].wen, q[0].wnum, q[0].wdata, exp_stamp());
                end
            end else if ({out_pc, out_wen, out_wnum, out_wdata, out_stamp} !== '0) begin
                n_err++; $display("FAIL rand_empty_%0d got pc=%h wen=%h data=%h stamp=%h want 0", i, out_pc, out_wen, out_wdata, out_stamp);
            end
            tick(0, $urandom, w, 5'($urandom), $urandom, $urandom_range(0, 99) < rdy_pct);
        end
        $display("test_random done");
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) tick(0, 32'(i), 4'h1, 5'd2, 32'(i), 0);
        for (int i = 0; i < 11; i++) tick(0, 0, 0, 0, 0, 1);
        n_cmp++; if (count !== 5'd5 || overflow !== 1'b1 || dropped !== 32'd1) begin n_err++; $display("FAIL mid_pre got %0d/%0b/%0d want 5/1/1", count, overflow, dropped); end
        tick(1, 32'h2000, 4'hF, 5'd9, 32'h9, 0);
        n_cmp++; if (count !== 5'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL mid_count got %0d/%0b want 0/0", count, out_valid); end
        n_cmp++; if (overflow !== 1'b0 || dropped !== 32'd0) begin n_err++; $display("FAIL mid_ovf got %0b/%0d want 0/0", overflow, dropped); end
        tick(0, 0, 0, 0, 0, 0);
        n_cmp++; if (count !== 5'd0 || out_pc !== 32'd0) begin n_err++; $display("FAIL mid_after got %0d/%h want 0/0", count, out_pc); end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1; in_pc = 0; in_wen = 0; in_wnum = 0; in_wdata = 0; out_ready = 0;
        m_ovf = 0; m_drop = 0; m_cyc = 0;
        test_reset();
        test_single();
        test_filter();
        test_fill_overflow();
        test_full_pop();
        test_streaming();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

Buffers the per-cycle commit records (pc, write strobe, destination register, write data) produced by the reference CPU's writeback debug port. It decouples the core from a slower trace consumer such as a golden-trace checker or a log dumper. Only records with a nonzero write strobe are captured. Overflow is reported through a sticky flag and a saturating drop counter, not by stalling the core.

## Interface
Parameters:
- DEPTH, 16, number of stored records; power of two, ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_pc  input  32  committed instruction pc (addr_t).
- in_wen  input  4  write strobe (strobe_t); a record is captured when nonzero.
- in_wnum  input  5  destination register index (regidx_t).
- in_wdata  input  32  value written to the destination register (word_t).
- out_valid  output  1  head record available.
- out_ready  input  1  consumer accepts the head record.
- out_pc  output  32  pc of the head record.
- out_wen  output  4  strobe of the head record.
- out_wnum  output  5  register index of the head record.
- out_wdata  output  32  data of the head record.
- out_stamp  output  32  capture cycle of the head record (see Configuration).
- count  output  $clog2(DEPTH)+1  number of stored records, 0..DEPTH.
- overflow  output  1  sticky; set when any record was dropped.
- dropped  output  32  number of dropped records, saturating.

## Operation
- Storage is a circular array with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate occupancy counter.
- push = (in_wen != 4'b0).
- pop = out_valid & out_ready.
- accept = push & (count < DEPTH | pop). When full and a pop happens in the same cycle, the push is accepted.
- drop = push & ~accept. On drop:
  - overflow is set to 1 and stays 1 until reset.
  - dropped is incremented; it saturates at 32'hFFFF_FFFF.
- On accept, the record is written to entry[tail] and tail advances.
- On pop, head advances.
- count updates as follows:
  - +1 on accept only.
  - −1 on pop only.
  - Unchanged when both occur in the same cycle.
- out_valid = (count != 0). While out_valid = 1, out_* reflect entry[head] combinationally from storage.
- While out_valid = 0, all out_* data fields are driven to 0.
- Records are stored bit-exact, including partial strobes such as 4'b0011. in_wnum = 0 with a nonzero strobe is captured like any other record.
- The pop side has no effect while out_valid = 0, regardless of out_ready.

## Timing
- Latency: a record presented in cycle N appears on out_* with out_valid = 1 in cycle N+1, provided the FIFO was empty.
- Throughput: one push and one pop per cycle.
- Order: records leave in strict arrival order.
- Empty FIFO with push and out_ready = 1: no bypass. The record is visible in the next cycle.
- Reset values:
  - head = 0, tail = 0, count = 0.
  - out_valid = 0, all out_* data fields = 0.
  - overflow = 0, dropped = 0, cycle counter = 0.
  - Storage contents are don't-care.
- Reset asserted mid-operation discards all stored records in the next cycle. Inputs presented during a reset cycle are ignored.

## Configuration
- COMMIT_TRACE_STAMP_EN defined:
  - A 32-bit free-running cycle counter resets to 0, increments every non-reset cycle and wraps from FFFF_FFFF to 0.
  - Each accepted record stores the counter value of its capture cycle.
  - out_stamp presents the stored value of the head record.
- Not defined:
  - No counter and no stamp storage are built.
  - out_stamp is tied to 32'h0.

## Test plan
- Single record: after reset, present pc=0xBFC0_0000, wen=4'hF, wnum=5, wdata=0x1234 for one cycle with out_ready=0 -> next cycle out_valid=1, out_* match the inputs, count=1. With STAMP_EN, out_stamp = capture cycle index.
- Filter: present 3 cycles with wen=0, then 1 cycle with wen=4'h3 -> exactly one record is stored, with out_wen=4'h3.
- Fill and overflow: DEPTH=16, out_ready=0, push 18 records with pc=i*4 -> count=16, overflow=1, dropped=2, head pc=0.
- Full with simultaneous pop: when full, push pc=0x100 with out_ready=1 -> count stays 16, the record is accepted, dropped is unchanged, the old head leaves.
- Streaming: continuous push with out_ready=1 for 100 cycles, pcs incrementing -> count ≤ 1, output pcs in order with no gaps, overflow=0.
- Reset mid-operation: with 5 records stored, assert reset for 1 cycle while pushing -> next cycle count=0, out_valid=0, overflow=0, dropped=0.
